mseq_multi_gen: RTL
===================

MSEQ_MULTI_GEN -- requirements
Module: mseq_multi_gen

Interface
REQ-001 SHALL have parameter MSEQ_DATA_WIDTH, default 16, LFSR length per channel (range 3..32).
REQ-002 SHALL have parameter MSEQ_NUM, default 8, number of independent M-sequence channels (range 1..32).
REQ-003 SHALL define local CW = max(1, clog2(MSEQ_NUM)).
REQ-004 SHALL have port MSEQ_clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port MSEQ_rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port MSEQ_cfg_valid, input, 1, the configuration request.
REQ-007 SHALL have port MSEQ_cfg_ready, output, 1, the block can accept configuration.
REQ-008 SHALL have port MSEQ_cfg_chan, input, CW, the target channel index.
REQ-009 SHALL have port MSEQ_cfg_poly, input, MSEQ_DATA_WIDTH, the feedback tap mask.
REQ-010 SHALL have port MSEQ_cfg_seed, input, MSEQ_DATA_WIDTH, the initial state.
REQ-011 SHALL have port MSEQ_en, input, MSEQ_NUM, the per-channel step enable.
REQ-012 SHALL have port MSEQ_output, output, MSEQ_NUM, the per-channel sequence bit.
REQ-013 SHALL have port MSEQ_valid, output, MSEQ_NUM, a per-channel flag that the channel is configured.
REQ-014 SHALL have port MSEQ_wrap, output, MSEQ_NUM, a per-channel one-cycle pulse when the sequence period completes.
REQ-015 SHALL have port MSEQ_lockup, output, MSEQ_NUM, a per-channel sticky flag that a zero seed was substituted.

Function
REQ-016 SHALL hold, per channel: state[W-1:0], poly[W-1:0], seed[W-1:0], cfg flag, lockup flag (W = MSEQ_DATA_WIDTH).
REQ-017 SHALL accept configuration on a cycle where MSEQ_cfg_valid & MSEQ_cfg_ready = 1.
REQ-018 SHALL drive MSEQ_cfg_ready low for exactly the one cycle after an accept, and high otherwise outside reset.
REQ-019 SHALL ignore an accept whose MSEQ_cfg_chan >= MSEQ_NUM, with no state change except the ready low cycle.
REQ-020 SHALL, on accept, load the channel at the next edge: poly = MSEQ_cfg_poly with bit W-1 forced to 1, seed = MSEQ_cfg_seed, state = seed, cfg = 1.
REQ-021 SHALL, if MSEQ_cfg_seed = 0, load seed and state with 1 and set lockup; a non-zero seed load SHALL clear lockup.
REQ-022 SHALL step a channel whose cfg = 1 and MSEQ_en[i] = 1 (Fibonacci form): fb = XOR-reduce(state & poly); state_next = {state[W-2:0], fb}.
REQ-023 SHALL give a configuration load priority over a step on the same channel in the same cycle; other channels SHALL step normally.
REQ-024 SHALL hold the state of a channel whose MSEQ_en[i] = 0 or cfg = 0.
REQ-025 SHALL make MSEQ_output[i] = state[W-1], registered with zero combinational path from inputs; the first bit after a load is seed[W-1].
REQ-026 SHALL make MSEQ_valid[i] = cfg[i].
REQ-027 SHALL pulse MSEQ_wrap[i] high for one cycle, in the cycle after a step whose state_next equals seed[i]; it SHALL NOT fire on a load.
REQ-028 SHALL, if a step produces an all-zero state (non-primitive poly), load 1 at the next step instead and set lockup[i].
REQ-029 SHALL apply no arithmetic beyond XOR and shift; widths are exact, with no truncation.

Reset
REQ-030 SHALL, on MSEQ_rst = 1 at an edge, clear every state, poly, seed, cfg and lockup register to 0, so MSEQ_output, MSEQ_valid, MSEQ_wrap and MSEQ_lockup are 0 and MSEQ_cfg_ready is 0.
REQ-031 SHALL drive MSEQ_cfg_ready to 1 on the first edge with MSEQ_rst = 0; reset mid-operation SHALL abandon any pending load.
REQ-032 SHALL allow MSEQ_rst to override configuration and stepping in the same cycle.

Verification (W=4, MSEQ_NUM=4)
REQ-033 SHALL check basic load and step: load ch0 with poly 4'b1001, seed 4'b0001, then en[0]=1 -> MSEQ_output[0] = 0,0,0,1 over the first four cycles; state returns to 0001 after 15 steps; MSEQ_wrap[0] pulses once per 15 steps.
REQ-034 SHALL check the zero seed: load ch1 with seed 0 -> state 0001, MSEQ_lockup[1] = 1; a reload with seed 4'b1000 -> lockup[1] = 0.
REQ-035 SHALL check the handshake: hold MSEQ_cfg_valid high for 4 cycles -> exactly 2 accepts, with MSEQ_cfg_ready alternating 1,0,1,0.
REQ-036 SHALL check a simultaneous load and step: ch0 is enabled mid-sequence and a load arrives for ch0 -> state = new seed next cycle, with no wrap pulse; ch2 keeps stepping undisturbed.
REQ-037 SHALL check an out-of-range index: cfg_chan = 5 with MSEQ_NUM=4 (CW=2, so use MSEQ_NUM=5 build with ch 7) -> no channel changes.
REQ-038 SHALL check reset mid-run: assert MSEQ_rst for 1 cycle during stepping -> all outputs 0, MSEQ_valid = 0, MSEQ_cfg_ready = 0 that cycle and 1 after.

Source files
------------

// File: rtl/mseq_multi_gen.sv
// Bank of independent Fibonacci LFSR (M-sequence) generators sharing one
// configuration port. Each channel holds its own tap mask, seed and state;
// a channel steps when configured and enabled, and reports period wrap and
// zero-state lockup recovery.
module mseq_multi_gen #(
  parameter int unsigned MSEQ_DATA_WIDTH = 16,
  parameter int unsigned MSEQ_NUM        = 8,
  localparam int unsigned CW = (MSEQ_NUM > 1) ? $clog2(MSEQ_NUM) : 1
) (
  input  logic                       MSEQ_clk,
  input  logic                       MSEQ_rst,
  input  logic                       MSEQ_cfg_valid,
  output logic                       MSEQ_cfg_ready,
  input  logic [CW-1:0]              MSEQ_cfg_chan,
  input  logic [MSEQ_DATA_WIDTH-1:0] MSEQ_cfg_poly,
  input  logic [MSEQ_DATA_WIDTH-1:0] MSEQ_cfg_seed,
  input  logic [MSEQ_NUM-1:0]        MSEQ_en,
  output logic [MSEQ_NUM-1:0]        MSEQ_output,
  output logic [MSEQ_NUM-1:0]        MSEQ_valid,
  output logic [MSEQ_NUM-1:0]        MSEQ_wrap,
  output logic [MSEQ_NUM-1:0]        MSEQ_lockup
);

  localparam int unsigned W = MSEQ_DATA_WIDTH;
  localparam int unsigned N = MSEQ_NUM;

  localparam logic [W-1:0] StateOne = W'(1);
  localparam logic [W-1:0] TopBit   = {1'b1, {(W-1){1'b0}}};
  // One wider than the index so that N itself is representable.
  localparam logic [CW:0]  NumLimit = (CW+1)'(N);

  // Per-channel storage.
  logic [W-1:0] state_q [N];
  logic [W-1:0] state_d [N];
  logic [W-1:0] poly_q  [N];
  logic [W-1:0] poly_d  [N];
  logic [W-1:0] seed_q  [N];
  logic [W-1:0] seed_d  [N];
  logic [N-1:0] cfg_q,  cfg_d;
  logic [N-1:0] lock_q, lock_d;
  logic [N-1:0] wrap_q, wrap_d;
  logic         ready_q, ready_d;

  // Configuration decode shared by all channels.
  logic         accept;
  logic         chan_ok;
  logic         seed_zero;
  logic [W-1:0] load_seed;
  logic [W-1:0] load_poly;

  assign accept    = MSEQ_cfg_valid & ready_q;
  assign chan_ok   = ({1'b0, MSEQ_cfg_chan} < NumLimit);
  assign seed_zero = (MSEQ_cfg_seed == '0);
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  assign load_seed = seed_zero ? StateOne : MSEQ_cfg_seed;
  // The top tap is always present so a non-zero state can never shift to zero.
  assign load_poly = MSEQ_cfg_poly | TopBit;

  // Ready drops for exactly the cycle following an accept.
  assign ready_d = ~accept;

  // Per-channel next state: a load wins over a step on the same channel.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      poly_d[i]  = poly_q[i];
      seed_d[i]  = seed_q[i];
      cfg_d[i]   = cfg_q[i];
      lock_d[i]  = lock_q[i];
      wrap_d[i]  = 1'b0;

      if (accept && chan_ok && (MSEQ_cfg_chan == CW'(i))) begin
        poly_d[i]  = load_poly;
        seed_d[i]  = load_seed;
        state_d[i] = load_seed;
        cfg_d[i]   = 1'b1;
        lock_d[i]  = seed_zero;
      end else if (cfg_q[i] && MSEQ_en[i]) begin
        if (state_q[i] == '0) begin
          // Recover from a dead state rather than stepping it.
          state_d[i] = StateOne;
          lock_d[i]  = 1'b1;
        end else begin
          state_d[i] = {state_q[i][W-2:0], ^(state_q[i] & poly_q[i])};
        end
        wrap_d[i] = (state_d[i] == seed_q[i]);
      end
    end
  end

  // State registers with synchronous reset overriding loads and steps.
  always_ff @(posedge MSEQ_clk) begin
    if (MSEQ_rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        state_q[i] <= '0;
        poly_q[i]  <= '0;
        seed_q[i]  <= '0;
      end
      cfg_q   <= '0;
      lock_q  <= '0;
      wrap_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        poly_q[i]  <= poly_d[i];
        seed_q[i]  <= seed_d[i];
      end
      cfg_q   <= cfg_d;
      lock_q  <= lock_d;
      wrap_q  <= wrap_d;
      ready_q <= ready_d;
    end
  end

  // Sequence bit is the MSB of the registered state.
  always_comb begin
    MSEQ_output = '0;
    for (int unsigned i = 0; i < N; i++) begin
      MSEQ_output[i] = state_q[i][W-1];
    end
  end

  assign MSEQ_cfg_ready = ready_q;
  assign MSEQ_valid     = cfg_q;
  assign MSEQ_wrap      = wrap_q;
  assign MSEQ_lockup    = lock_q;

endmodule
